// File: rtl/core_ram_responder.sv
// core_ram_responder: data-memory responder for the core's split RAM interface.
// The read port is combinational and the write port is registered; each is byte or word wide.
// Storage is split into an even bank and an odd bank, so a word at any address, including
// the top byte that wraps to byte 0, touches each bank exactly once per cycle.
// After reset a clear engine zeroes every row, then ready rises and stays high.
// The block also keeps a sticky error flag and saturating read/write counters.
// Optional build macro: CORE_RAM_BYPASS_EN. When defined, a read forwards the incoming
// write bytes for any byte address it shares with a same-cycle valid write.
module core_ram_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_rd_en_i,
  input  logic              ram_rd_we_i,
  input  logic [19:0]       ram_rd_addr_i,
  output logic [15:0]       ram_rd_data_o,
  input  logic              ram_wr_en_i,
  input  logic              ram_wr_we_i,
  input  logic [19:0]       ram_wr_addr_i,
  input  logic [15:0]       ram_wr_data_i,
  input  logic              err_clr_i,
  output logic              ready_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  localparam int unsigned RowW = ADDR_W - 1;
  localparam int unsigned Rows = 2 ** RowW;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [RowW-1:0]  RowOne = {{(RowW - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W - 1){1'b0}}, 1'b1};

  // Even bytes live in bank0, odd bytes in bank1; row = byte address >> 1.
  logic [7:0] bank0_q [Rows];
  logic [7:0] bank1_q [Rows];

  logic [0:0]       state_q, state_d;
  logic [RowW-1:0]  clr_idx_q, clr_idx_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic              ready;
  logic              rd_in_range, wr_in_range;
  logic              rd_valid, wr_valid;
  logic [ADDR_W-1:0] rd_a0, rd_a1, wr_a0, wr_a1;
  logic [7:0]        rd_b0, rd_b1;

  logic              b0_we, b1_we;
  logic [RowW-1:0]   b0_row, b1_row;
  logic [7:0]        b0_wdata, b1_wdata;

  assign ready = (state_q == S_READY);

  // Address decode: upper bits must be zero; the second byte of a word wraps mod 2^ADDR_W.
  always_comb begin
    rd_in_range = (ram_rd_addr_i[19:ADDR_W] == '0);
    wr_in_range = (ram_wr_addr_i[19:ADDR_W] == '0);
    rd_a0       = ram_rd_addr_i[ADDR_W-1:0];
    rd_a1       = rd_a0 + AddrOne;
    wr_a0       = ram_wr_addr_i[ADDR_W-1:0];
    wr_a1       = wr_a0 + AddrOne;
    rd_valid    = ram_rd_en_i && ready && rd_in_range;
    wr_valid    = ram_wr_en_i && ready && wr_in_range;
  end

  // Combinational read path, with optional per-byte forwarding from the write port.
  always_comb begin
    rd_b0 = rd_a0[0] ? bank1_q[rd_a0[ADDR_W-1:1]] : bank0_q[rd_a0[ADDR_W-1:1]];
    rd_b1 = rd_a1[0] ? bank1_q[rd_a1[ADDR_W-1:1]] : bank0_q[rd_a1[ADDR_W-1:1]];
`ifdef CORE_RAM_BYPASS_EN
    if (wr_valid) begin
      if (rd_a0 == wr_a0) begin
        rd_b0 = ram_wr_data_i[7:0];
      end else if (ram_wr_we_i && (rd_a0 == wr_a1)) begin
        rd_b0 = ram_wr_data_i[15:8];
      end
      if (rd_a1 == wr_a0) begin
        rd_b1 = ram_wr_data_i[7:0];
      end else if (ram_wr_we_i && (rd_a1 == wr_a1)) begin
        rd_b1 = ram_wr_data_i[15:8];
      end
    end
`endif
    ram_rd_data_o = 16'h0000;
    if (rd_valid) begin
      ram_rd_data_o = ram_rd_we_i ? {rd_b1, rd_b0} : {8'h00, rd_b0};
    end
  end

  // Bank write steering: the clear sweep owns both banks until ready.
  always_comb begin
    b0_we    = 1'b0;
    b1_we    = 1'b0;
    b0_row   = '0;
    b1_row   = '0;
    b0_wdata = 8'h00;
    b1_wdata = 8'h00;
    if (state_q == S_CLEAR) begin
      b0_we  = 1'b1;
      b1_we  = 1'b1;
      b0_row = clr_idx_q;
      b1_row = clr_idx_q;
    end else if (wr_valid) begin
      if (wr_a0[0]) begin
        b1_we    = 1'b1;
        b1_row   = wr_a0[ADDR_W-1:1];
        b1_wdata = ram_wr_data_i[7:0];
      end else begin
        b0_we    = 1'b1;
        b0_row   = wr_a0[ADDR_W-1:1];
        b0_wdata = ram_wr_data_i[7:0];
      end
      // Word writes: the second byte always lands in the other bank.
      if (ram_wr_we_i) begin
        if (wr_a1[0]) begin
          b1_we    = 1'b1;
          b1_row   = wr_a1[ADDR_W-1:1];
          b1_wdata = ram_wr_data_i[15:8];
        end else begin
          b0_we    = 1'b1;
          b0_row   = wr_a1[ADDR_W-1:1];
          b0_wdata = ram_wr_data_i[15:8];
        end
      end
    end
  end

  // Even bank storage; not reset, the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (b0_we) begin
      bank0_q[b0_row] <= b0_wdata;
    end
  end

  // Odd bank storage; not reset, the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (b1_we) begin
      bank1_q[b1_row] <= b1_wdata;
    end
  end

  // Clear sequencer: one row per cycle, then ready forever.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + RowOne;
      if (clr_idx_q == '1) begin
        state_d = S_READY;
      end
    end
  end

  // Sticky error and saturating counters; a new error beats a coincident clear.
  always_comb begin
    err_d      = err_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if ((ram_rd_en_i && !rd_valid) || (ram_wr_en_i && !wr_valid)) begin
      err_d = 1'b1;
    end
    if (rd_valid && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + CntOne;
    end
    if (wr_valid && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + CntOne;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      clr_idx_q  <= '0;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign ready_o    = ready;
  assign err_o      = err_q;
  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_core_ram_responder.sv
// Directed bench for core_ram_responder: vector table plus reset/clear sequences.
module tb_core_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, rd_we, wr_en, wr_we, err_clr;
  logic [19:0] rd_addr, wr_addr;
  logic [15:0] wr_data, rd_data;
  logic        ready, err;
  logic [15:0] rd_count, wr_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_ram_responder #(
    .ADDR_W(12),
    .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ram_rd_en_i  (rd_en),
    .ram_rd_we_i  (rd_we),
    .ram_rd_addr_i(rd_addr),
    .ram_rd_data_o(rd_data),
    .ram_wr_en_i  (wr_en),
    .ram_wr_we_i  (wr_we),
    .ram_wr_addr_i(wr_addr),
    .ram_wr_data_i(wr_data),
    .err_clr_i    (err_clr),
    .ready_o      (ready),
    .err_o        (err),
    .rd_count_o   (rd_count),
    .wr_count_o   (wr_count)
  );

  typedef struct {
    logic        rd_en;
    logic        rd_we;
    logic [19:0] rd_addr;
    logic        wr_en;
    logic        wr_we;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        err_clr;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

`ifdef CORE_RAM_BYPASS_EN
  localparam logic [15:0] ExpRaw  = 16'h22A5;
  localparam logic [15:0] ExpWrap = 16'h9988;
`else
  localparam logic [15:0] ExpRaw  = 16'h2211;
  localparam logic [15:0] ExpWrap = 16'h1234;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle();
    rd_en = 0; rd_we = 0; rd_addr = '0;
    wr_en = 0; wr_we = 0; wr_addr = '0; wr_data = '0;
    err_clr = 0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready, bounded so a stuck clear still reaches the summary.
  task automatic wait_ready(input int start, output int n);
    n = start;
    while (!ready && n < 4000) begin
      edge1();
      n++;
    end
  endtask

  vec_t vecs[22];
  int   n;
  int   bad;

  initial begin
    vecs[0]  = '{0, 0, 20'h0,     1, 1, 20'h00101, 16'hBEEF, 0, 16'h0000, 0};
    vecs[1]  = '{1, 0, 20'h00101, 0, 0, 20'h0,     16'h0,    0, 16'h00EF, 0};
    vecs[2]  = '{1, 0, 20'h00102, 0, 0, 20'h0,     16'h0,    0, 16'h00BE, 0};
    vecs[3]  = '{1, 1, 20'h00100, 0, 0, 20'h0,     16'h0,    0, 16'hEF00, 0};
    vecs[4]  = '{0, 0, 20'h0,     1, 1, 20'h00FFF, 16'h1234, 0, 16'h0000, 0};
    vecs[5]  = '{1, 0, 20'h00FFF, 0, 0, 20'h0,     16'h0,    0, 16'h0034, 0};
    vecs[6]  = '{1, 0, 20'h00000, 0, 0, 20'h0,     16'h0,    0, 16'h0012, 0};
    vecs[7]  = '{1, 1, 20'h00FFF, 0, 0, 20'h0,     16'h0,    0, 16'h1234, 0};
    vecs[8]  = '{0, 0, 20'h0,     1, 0, 20'h01000, 16'h0077, 0, 16'h0000, 1};
    vecs[9]  = '{1, 1, 20'h20000, 0, 0, 20'h0,     16'h0,    0, 16'h0000, 1};
    vecs[10] = '{1, 0, 20'h00000, 0, 0, 20'h0,     16'h0,    0, 16'h0012, 1};
    vecs[11] = '{0, 0, 20'h0,     0, 0, 20'h0,     16'h0,    1, 16'h0000, 0};
    vecs[12] = '{1, 0, 20'h30000, 0, 0, 20'h0,     16'h0,    1, 16'h0000, 1};
    vecs[13] = '{0, 0, 20'h0,     0, 0, 20'h0,     16'h0,    1, 16'h0000, 0};
    vecs[14] = '{0, 0, 20'h0,     1, 0, 20'h00201, 16'h0011, 0, 16'h0000, 0};
    vecs[15] = '{0, 0, 20'h0,     1, 0, 20'h00202, 16'h0022, 0, 16'h0000, 0};
    vecs[16] = '{1, 1, 20'h00201, 1, 1, 20'h00200, 16'hA5C3, 0, ExpRaw,   0};
    vecs[17] = '{1, 1, 20'h00201, 0, 0, 20'h0,     16'h0,    0, 16'h22A5, 0};
    vecs[18] = '{1, 0, 20'h00200, 0, 0, 20'h0,     16'h0,    0, 16'h00C3, 0};
    vecs[19] = '{1, 1, 20'h00FFF, 1, 1, 20'h00FFF, 16'h9988, 0, ExpWrap,  0};
    vecs[20] = '{1, 0, 20'h00000, 0, 0, 20'h0,     16'h0,    0, 16'h0099, 0};
    vecs[21] = '{0, 0, 20'h0,     1, 0, 20'hFFFFF, 16'h0055, 0, 16'h0000, 1};

    // Reset state, with a read request held during reset.
    idle();
    rst = 0;
    rd_en = 1; rd_we = 1;
    #12;
    chk("rd_data_in_reset", int'(rd_data), 0);
    chk("ready_in_reset", int'(ready), 0);
    chk("err_in_reset", int'(err), 0);
    chk("rd_count_in_reset", int'(rd_count), 0);
    chk("wr_count_in_reset", int'(wr_count), 0);
    idle();
    edge1();
    rst = 1;
    wait_ready(0, n);
    chk("clear_len", n, 2048);

    // Table-driven functional vectors.
    for (int i = 0; i < 22; i++) begin
      rd_en   = vecs[i].rd_en;
      rd_we   = vecs[i].rd_we;
      rd_addr = vecs[i].rd_addr;
      wr_en   = vecs[i].wr_en;
      wr_we   = vecs[i].wr_we;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      err_clr = vecs[i].err_clr;
      #3;
      chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].exp_rd));
      edge1();
      chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
      if (i == 3) begin
        chk("wr_count_after_beef", int'(wr_count), 1);
        chk("rd_count_after_beef", int'(rd_count), 3);
      end
      if (i == 10) begin
        chk("rd_count_after_bad", int'(rd_count), 7);
        chk("wr_count_after_bad", int'(wr_count), 2);
      end
    end
    idle();
    chk("rd_count_final", int'(rd_count), 12);
    chk("wr_count_final", int'(wr_count), 6);

    // Reset after ready with a write pending: async drop, nothing committed.
    wr_en = 1; wr_we = 1; wr_addr = 20'h00300; wr_data = 16'hFFFF;
    #2;
    rst = 0;
    #1;
    chk("ready_drop_async", int'(ready), 0);
    chk("err_reset_async", int'(err), 0);
    chk("rd_count_reset", int'(rd_count), 0);
    chk("wr_count_reset", int'(wr_count), 0);
    edge1();
    idle();
    rst = 1;
    for (int i = 0; i < 500; i++) edge1();
    chk("ready_mid_clear", int'(ready), 0);

    // One-cycle reset at cycle 500 of the clear, then a full restart.
    rst = 0;
    #1;
    chk("ready_during_restart", int'(ready), 0);
    edge1();
    rst = 1;
    for (int i = 0; i < 5; i++) edge1();
    rd_en = 1; rd_we = 1; rd_addr = 20'h00010;
    #2;
    chk("rd_during_clear", int'(rd_data), 0);
    edge1();
    chk("err_during_clear", int'(err), 1);
    chk("rd_count_during_clear", int'(rd_count), 0);
    idle();
    err_clr = 1;
    edge1();
    chk("err_clr_pulse", int'(err), 0);
    idle();
    wait_ready(7, n);
    chk("clear_restart_len", n, 2048);
    chk("wr_count_after_restart", int'(wr_count), 0);

    // Every word must be zero again, including bytes written earlier.
    bad = 0;
    rd_en = 1; rd_we = 1;
    for (int i = 0; i < 2048; i++) begin
      rd_addr = 20'(2 * i);
      #1;
      if (rd_data !== 16'h0000) bad++;
    end
    chk("sweep_nonzero_words", bad, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
